// File: rtl/stream_width_packer.sv
// stream_width_packer: packs Ratio narrow input beats into one wide output
// word, placed ahead of the source side of a clock-crossing FIFO.
// A word is emitted once Ratio beats are collected or a beat carrying
// in_last_i arrives. out_keep_o marks the filled lanes and is contiguous
// from lane 0.
//
// Handshake (both sides): a transfer occurs on a rising clk_i edge where
// valid && ready. A producer must hold valid and its payload until that
// edge. Once out_valid_o is high, out_data_o, out_keep_o and out_last_o
// hold until the word is consumed.
module stream_width_packer #(
   parameter int InWidth = 8,
   parameter int Ratio   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic [InWidth-1:0]         in_data_i,
   input  logic                       in_last_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   output logic [InWidth*Ratio-1:0]   out_data_o,
   output logic [Ratio-1:0]           out_keep_o,
   output logic                       out_last_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i
);

   localparam int OutWidth = InWidth * Ratio;
   localparam int CntW     = $clog2(Ratio);

   // FILL assembles a word and HOLD presents it. The state is exactly out_valid_q.
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   logic [OutWidth-1:0] data_q, data_d;
   logic [Ratio-1:0]    keep_q, keep_d;
   logic                last_q, last_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   state_e              state;
   logic                in_fire;
   logic                out_fire;

   assign state      = out_valid_q ? HOLD : FILL;
   assign in_ready_o = (state == FILL) || out_ready_i;
   assign in_fire    = in_valid_i && in_ready_o;
   assign out_fire   = (state == HOLD) && out_ready_i;

   assign out_data_o  = data_q;
   assign out_keep_o  = keep_q;
   assign out_last_o  = last_q;
   assign out_valid_o = out_valid_q;

   // Next word state: retire the held word, then place an accepted beat in lane cnt_q.
   always_comb begin
      data_d      = data_q;
      keep_d      = keep_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      if (out_fire) begin
         // cnt_q already wrapped to 0 when this word completed
         data_d      = '0;
         keep_d      = '0;
         last_d      = 1'b0;
         out_valid_d = 1'b0;
      end
      if (in_fire) begin
         for (int k = 0; k < Ratio; k++) begin
            if (cnt_q == CntW'(k)) begin
               data_d[k*InWidth +: InWidth] = in_data_i;
               keep_d[k]                    = 1'b1;
            end
         end
         if ((cnt_q == CntW'(Ratio - 1)) || in_last_i) begin
            out_valid_d = 1'b1;
            last_d      = in_last_i;
            cnt_d       = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Word registers. clr_i has priority over any handshake in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q      <= '0;
         keep_q      <= '0;
         last_q      <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (clr_i) begin
         data_q      <= '0;
         keep_q      <= '0;
         last_q      <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         data_q      <= data_d;
         keep_q      <= keep_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifndef SYNTHESIS
   // Lane indexing and counter wrap rely on a power-of-two Ratio of at least 2.
   if ((Ratio < 2) || ((Ratio & (Ratio - 1)) != 0)) begin : g_ratio_chk
      $error("stream_width_packer: Ratio must be a power of two >= 2");
   end

   // A stalled word must not change under the consumer.
   a_stable_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i && !clr_i) |=>
      ($stable(out_data_o) && $stable(out_keep_o) && $stable(out_last_o) && out_valid_o));

   // A presented word always carries at least one lane.
   a_keep_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_valid_o |-> (out_keep_o != '0));
`endif

endmodule

// File: tb/tb_stream_width_packer.sv
// Bench for stream_width_packer (InWidth=8, Ratio=4).
// The reference model holds the beats of the word being assembled in a
// queue. A finished word is pushed onto exp_q. A monitor on the falling
// edge compares every DUT output against the model.
module tb_stream_width_packer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int OW = IW * R;
  localparam int EW = OW + R + 1;   // {last, keep, data}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready_o;
  logic [OW-1:0] out_data_o;
  logic [R-1:0]  out_keep_o;
  logic          out_last_o;
  logic          out_valid_o;
  logic          out_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 1;   // 0 = stall, 1 = always ready, 2 = random

  logic [IW-1:0] part_q[$];
  logic [EW-1:0] exp_q[$];

  stream_width_packer #(.InWidth(IW), .Ratio(R)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_keep_o  (out_keep_o),
    .out_last_o  (out_last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build the expected word from the collected beats with plain arithmetic.
  function automatic logic [EW-1:0] make_word(input logic last);
    logic [OW-1:0] d;
    logic [R-1:0]  k;
    d = '0;
    for (int i = 0; i < part_q.size(); i++) d[i*IW +: IW] = part_q[i];
    k = R'((1 << part_q.size()) - 1);
    return {last, k, d};
  endfunction

  // ---------------- driver tasks ----------------
  // Ready driver: updates out_ready shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Present one beat and hold it until it is accepted. Returns the number
  // of cycles spent waiting.
  task automatic send(input logic [IW-1:0] d, input logic l, output int waited);
    logic acc;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 200) begin
        chk("send_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic pending;
      logic [EW-1:0] e;
      pending = (exp_q.size() != 0);
      chk("in_ready", 64'(in_ready_o), 64'(!pending || out_ready));
      chk("out_valid", 64'(out_valid_o), 64'(pending));
      if (pending && out_valid_o) begin
        e = exp_q[0];
        chk("out_data", 64'(out_data_o), 64'(e[OW-1:0]));
        chk("out_keep", 64'(out_keep_o), 64'(e[OW +: R]));
        chk("out_last", 64'(out_last_o), 64'(e[EW-1]));
      end
      if (clr) begin
        part_q.delete();
        if (pending) void'(exp_q.pop_front());
      end else begin
        if (pending && out_ready) void'(exp_q.pop_front());
        if (in_valid && (!pending || out_ready)) begin
          part_q.push_back(in_data);
          if (part_q.size() == R || in_last) begin
            exp_q.push_back(make_word(in_last));
            part_q.delete();
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int n;
    logic lst;

    // reset
    #12;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data",  64'(out_data_o),  64'd0);
    chk("rst_keep",  64'(out_keep_o),  64'd0);
    chk("rst_last",  64'(out_last_o),  64'd0);
    chk("rst_ready", 64'(in_ready_o),  64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // full word, no last
    rdy_mode = 1;
    send(8'h11, 1'b0, w);
    send(8'h22, 1'b0, w);
    send(8'h33, 1'b0, w);
    send(8'h44, 1'b0, w);
    idle(3);

    // short packet
    send(8'hAA, 1'b0, w);
    send(8'hBB, 1'b1, w);
    idle(3);

    // stall a full word for 5 cycles, then release ready with a beat pending
    rdy_mode = 0;
    out_ready = 1'b0;
    send(8'h61, 1'b0, w);
    send(8'h62, 1'b0, w);
    send(8'h63, 1'b0, w);
    send(8'h64, 1'b0, w);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready_o), 64'd0);
      @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    out_ready = 1'b1;
    send(8'h55, 1'b0, w);
    chk("release_same_cycle", 64'(w), 64'd0);
    send(8'h56, 1'b1, w);
    idle(3);

    // 8 back-to-back beats, no bubbles
    for (int i = 1; i <= 8; i++) begin
      send(IW'(i), 1'b0, w);
      chk("b2b_wait", 64'(w), 64'd0);
    end
    idle(3);

    // partial word cleared, then a clr colliding with a handshake
    send(8'h71, 1'b0, w);
    send(8'h72, 1'b0, w);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    in_data = 8'h99;
    in_valid = 1'b1;
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    in_valid = 1'b0;
    send(8'hC1, 1'b0, w);
    send(8'hC2, 1'b0, w);
    send(8'hC3, 1'b0, w);
    send(8'hC4, 1'b0, w);
    idle(3);

    // lone last beat
    send(8'hD7, 1'b1, w);
    idle(3);

    // async reset while holding a word
    rdy_mode = 0;
    out_ready = 1'b0;
    send(8'h81, 1'b0, w);
    send(8'h82, 1'b0, w);
    send(8'h83, 1'b0, w);
    send(8'h84, 1'b0, w);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    part_q.delete();
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_data",  64'(out_data_o),  64'd0);
    chk("arst_keep",  64'(out_keep_o),  64'd0);
    chk("arst_ready", 64'(in_ready_o),  64'd1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    idle(2);

    // randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      lst = ($urandom_range(0, 4) == 0);
      send(IW'($urandom), lst, w);
      n = $urandom_range(0, 3);
      if (n == 0) idle($urandom_range(1, 3));
    end
    send(8'hEE, 1'b1, w);

    // drain
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_partial", 64'(part_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
